prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream program loader: the writer side of instruction memory, which the CPU fetch path only ever reads.
- Takes a framed byte stream (length, 16-bit words, checksum) and writes the words into RAM port b, starting at BASE_ADDR.
- Holds the CPU, Program_Counter and FSM in reset via CpuHold until the image has been written and verified.
- Sits between the off-chip byte receiver and the RAM write port at CPU top level.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 16, RAM word width; words are always sent as 2 bytes, high byte first.
- BASE_ADDR, 0, RAM address of word 0.
- DEPTH, 1024, maximum words accepted; a length above this is an error.

Ports:
- Clk  in  1  system clock, all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse that begins a load.
- RxData  in  8  incoming byte.
- RxValid  in  1  RxData is valid.
- RxReady  out  1  loader accepts a byte; a transfer occurs on a cycle with RxValid && RxReady.
- RamData  out  DATA_W  write data to RAM port b.
- RamAddr  out  ADDR_W  write address to RAM port b.
- RamWe  out  1  write enable to RAM port b.
- CpuHold  out  1  held high while loading and in error; ORed into CPU reset.
- Done  out  1  image loaded and checksum matched; sticky.
- Err  out  1  length overflow or checksum mismatch; sticky.
- WordCnt  out  ADDR_W+1  number of words written so far.

Behaviour:
- Reset (Rst high at an edge):
  - State goes to IDLE.
  - RxReady=0, RamWe=0, RamAddr=BASE_ADDR, RamData=0, CpuHold=0, Done=0, Err=0, WordCnt=0.
  - Internal length N=0, checksum accumulator=0.
  - Applies mid-operation: any partial word is discarded and no write issues on the edge after Rst.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CKSUM, DONE, ERROR.
- IDLE:
  - Start -> LEN_HI.
  - CpuHold=1 from the next cycle; accumulator and WordCnt cleared.
- LEN_HI / LEN_LO:
  - RxReady=1; each accepted byte forms N[15:8] then N[7:0].
  - From LEN_LO:
    - N>DEPTH -> ERROR.
    - N==0 -> CKSUM.
    - Otherwise -> DATA_HI.
- DATA_HI / DATA_LO:
  - RxReady=1; accepted bytes form the word, high byte first.
  - DATA_LO -> WRITE on the accepting edge.
- WRITE (exactly one cycle):
  - RxReady=0, RamWe=1, RamAddr=BASE_ADDR+WordCnt, RamData=assembled word.
  - The write occurs on the edge leaving WRITE; WordCnt increments on that same edge.
  - Next state: CKSUM if the new WordCnt==N, else DATA_HI.
- Latency and throughput:
  - RamWe is asserted in the cycle immediately after the low byte is accepted.
  - Peak rate is 2 bytes per 3 cycles.
- Stall: RxValid low in any receiving state holds the state; no timeout.
- Checksum:
  - The accumulator XORs every accepted byte from LEN_HI through the final DATA_LO.
  - CKSUM: RxReady=1; the accepted byte is compared with the accumulator.
  - Equal -> DONE; unequal -> ERROR.
- DONE: Done=1, CpuHold=0, RxReady=0. Bytes arriving here are not accepted.
- ERROR: Err=1, CpuHold=1, RxReady=0.
- Start behaviour:
  - In DONE or ERROR, Start -> LEN_HI; Done and Err clear on that edge and WordCnt resets to 0.
  - In any loading state, Start is ignored.
- Rst and Start in the same cycle: Rst wins.
- RamWe is never high outside WRITE. RamAddr holds its last value otherwise.
- Address wrap: cannot occur, because N≤DEPTH and BASE_ADDR+DEPTH-1 must fit in ADDR_W; the integrator guarantees this.

Test Plan:
- Normal load:
  - Stimulus: Rst, then Start, then bytes 00 02 12 34 AB CD 42 back-to-back.
  - Required: RAM[0]=0x1234, RAM[1]=0xABCD; exactly 2 RamWe pulses; Done=1, Err=0, CpuHold=0, WordCnt=2.
- Bad checksum:
  - Stimulus: same frame with checksum byte 0x43.
  - Required: Err=1, Done=0, CpuHold stays 1; both RAM writes still occurred.
- Length overflow:
  - Stimulus: DEPTH=1024, bytes 04 01.
  - Required: ERROR right after the second byte; no RamWe; RxReady=0 after.
- Zero length and stalls:
  - Stimulus: bytes 00 00 00, with RxValid toggled low for 5 cycles between bytes.
  - Required: Done=1, WordCnt=0, no writes; state holds during the stall cycles.
- Reset mid-load:
  - Stimulus: Rst asserted after byte 0x12 of the normal frame.
  - Required: IDLE, all outputs at reset values, no write.
  - Follow-up: a fresh Start plus the full frame then loads correctly.
- Start handling:
  - Stimulus: Start pulsed during DATA_HI, then Start after DONE followed by a new frame 00 01 BE EF 50.
  - Required: the first Start is ignored; the second clears Done, RAM[0]=0xBEEF, Done=1.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream and RAM-write-port bundle between the byte receiver, the loader
// and instruction RAM port b.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;

  // Environment side: byte source and RAM sink.
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  ram_data,
    input  ram_addr,
    input  ram_we
  );

  // Loader side.
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output ram_data,
    output ram_addr,
    output ram_we
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses a framed byte stream (length, 16-bit words, XOR checksum)
// into instruction RAM port b and holds the CPU in reset until the image is verified.
module prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  prog_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_HI  = 4'd1,
    LEN_LO  = 4'd2,
    DATA_HI = 4'd3,
    DATA_LO = 4'd4,
    WRITE   = 4'd5,
    CKSUM   = 4'd6,
    DONE    = 4'd7,
    ERROR   = 4'd8
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_nxt;
  logic [BYTE_W-1:0]  acc_q;
  logic [BYTE_W-1:0]  acc_nxt;
  logic [BYTE_W-1:0]  hi_q;
  logic [BYTE_W-1:0]  hi_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic               ready_nxt;
  logic               we_nxt;
  logic               hold_nxt;
  logic               done_nxt;
  logic               err_nxt;

  logic               accept;
  logic [LEN_W-1:0]   len_rx;
  logic [CNT_W-1:0]   cnt_inc;

  assign accept  = bus.rx_valid && bus.rx_ready;
  assign len_rx  = {len_q[LEN_W-1:BYTE_W], bus.rx_data};
  assign cnt_inc = word_cnt + CNT_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath decode; outputs are registered from the next state
  // so each one is valid in the cycle the FSM actually occupies that state.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    acc_nxt   = acc_q;
    hi_nxt    = hi_q;
    cnt_nxt   = word_cnt;
    addr_nxt  = bus.ram_addr;
    data_nxt  = bus.ram_data;

    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_nxt = LEN_HI;
          len_nxt   = '0;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_nxt   = {bus.rx_data, len_q[BYTE_W-1:0]};
          acc_nxt   = acc_q ^ bus.rx_data;
          state_nxt = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_nxt = len_rx;
          acc_nxt = acc_q ^ bus.rx_data;
          if (32'(len_rx) > DEPTH) begin
            state_nxt = ERROR;
          end else if (len_rx == '0) begin
            state_nxt = CKSUM;
          end else begin
            state_nxt = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) begin
          hi_nxt    = bus.rx_data;
          acc_nxt   = acc_q ^ bus.rx_data;
          state_nxt = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept) begin
          acc_nxt   = acc_q ^ bus.rx_data;
          data_nxt  = DATA_W'({hi_q, bus.rx_data});
          addr_nxt  = ADDR_W'(BASE_ADDR) + word_cnt[ADDR_W-1:0];
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        cnt_nxt = cnt_inc;
        if (32'(cnt_inc) == 32'(len_q)) begin
          state_nxt = CKSUM;
        end else begin
          state_nxt = DATA_HI;
        end
      end
      CKSUM: begin
        if (accept) begin
          state_nxt = (bus.rx_data == acc_q) ? DONE : ERROR;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    ready_nxt = (state_nxt == LEN_HI) || (state_nxt == LEN_LO) ||
                (state_nxt == DATA_HI) || (state_nxt == DATA_LO) ||
                (state_nxt == CKSUM);
    we_nxt    = (state_nxt == WRITE);
    hold_nxt  = (state_nxt != IDLE) && (state_nxt != DONE);
    done_nxt  = (state_nxt == DONE);
    err_nxt   = (state_nxt == ERROR);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q        <= '0;
      acc_q        <= '0;
      hi_q         <= '0;
      word_cnt     <= '0;
      bus.ram_addr <= ADDR_W'(BASE_ADDR);
      bus.ram_data <= '0;
      bus.ram_we   <= 1'b0;
      bus.rx_ready <= 1'b0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      len_q        <= len_nxt;
      acc_q        <= acc_nxt;
      hi_q         <= hi_nxt;
      word_cnt     <= cnt_nxt;
      bus.ram_addr <= addr_nxt;
      bus.ram_data <= data_nxt;
      bus.ram_we   <= we_nxt;
      bus.rx_ready <= ready_nxt;
      cpu_hold     <= hold_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
    end
  end

  // Write strobe and byte acceptance must track the FSM exactly.
  a_we_in_write: assert property (@(posedge clk) disable iff (rst)
    bus.ram_we == (state == WRITE));
  a_done_err_excl: assert property (@(posedge clk) disable iff (rst)
    !(done && err));

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a frame-position reference model predicts every
// output each cycle, plus literal checks on the directed frames.
module tb_prog_loader;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned CNT_W     = ADDR_W + 1;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold;
  logic done;
  logic err;
  logic [ADDR_W:0] word_cnt;

  prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int total;
  int bad;
  int we_count;
  logic [15:0] dut_ram [0:DEPTH-1];
  logic [15:0] mram    [0:DEPTH-1];
  logic [7:0]  frame[$];
  bit          start_noise;

  // Reference model state: position of the next byte within the current frame.
  bit              armed;
  bit              m_active;
  bit              m_wr;
  bit              m_done;
  bit              m_err;
  int              m_pos;
  int              m_n;
  int              m_nhi;
  int              m_cnt;
  logic [7:0]      m_acc;
  logic [7:0]      m_hi;
  logic [ADDR_W-1:0] m_addr;
  logic [15:0]     m_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_frame(input int gap_min, input int gap_max);
    foreach (frame[i]) begin
      int  waited;
      bit  took;
      repeat ($urandom_range(gap_min, gap_max)) begin
        bus.rx_valid = 1'b0;
        start = start_noise && ($urandom_range(0, 7) == 0);
        tick();
        start = 1'b0;
      end
      bus.rx_data  = frame[i];
      bus.rx_valid = 1'b1;
      took   = 1'b0;
      waited = 0;
      while (!took && waited < 50) begin
        start = start_noise && ($urandom_range(0, 7) == 0);
        @(negedge clk);
        took = bus.rx_ready;
        tick();
        start = 1'b0;
        waited++;
      end
      bus.rx_valid = 1'b0;
      if (!took) begin
        total++;
        bad++;
        $display("FAIL byte_timeout: byte %0d not accepted in 50 cycles, want accepted", i);
        return;
      end
    end
  endtask

  task automatic build_frame(input int n, input bit corrupt);
    logic [7:0]  cs;
    logic [15:0] w;
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    cs = 8'(n >> 8) ^ 8'(n);
    for (int k = 0; k < n; k++) begin
      w = 16'($urandom);
      frame.push_back(w[15:8]);
      frame.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    if (corrupt) cs = cs ^ 8'(1 << $urandom_range(0, 7));
    frame.push_back(cs);
  endtask

  initial begin
    int w0;
    rst = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    start_noise = 1'b0;
    total = 0;
    bad = 0;
    we_count = 0;
    armed = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dut_ram[i] = 16'h0;
      mram[i] = 16'h0;
    end

    fork
      // Model: advance one clock edge using the inputs the DUT samples.
      forever begin
        logic [7:0] b;
        @(posedge clk);
        if (rst) begin
          armed = 1'b1;
          m_active = 1'b0; m_wr = 1'b0; m_done = 1'b0; m_err = 1'b0;
          m_cnt = 0; m_pos = 0; m_addr = ADDR_W'(BASE_ADDR); m_data = 16'h0;
        end else if (m_wr) begin
          mram[m_addr] = m_data;
          m_cnt++;
          m_wr = 1'b0;
        end else if (!m_active) begin
          if (start) begin
            m_active = 1'b1; m_done = 1'b0; m_err = 1'b0;
            m_cnt = 0; m_pos = 0; m_acc = 8'h00;
          end
        end else if (bus.rx_valid) begin
          b = bus.rx_data;
          if (m_pos == 0) begin
            m_nhi = int'(b);
            m_acc = m_acc ^ b;
          end else if (m_pos == 1) begin
            m_n = m_nhi * 256 + int'(b);
            m_acc = m_acc ^ b;
            if (m_n > int'(DEPTH)) begin
              m_active = 1'b0;
              m_err = 1'b1;
            end
          end else if (m_pos < 2 + 2 * m_n) begin
            m_acc = m_acc ^ b;
            if ((m_pos % 2) == 0) begin
              m_hi = b;
            end else begin
              m_wr = 1'b1;
              m_addr = ADDR_W'(int'(BASE_ADDR) + m_cnt);
              m_data = {m_hi, b};
            end
          end else begin
            m_active = 1'b0;
            if (b == m_acc) m_done = 1'b1;
            else m_err = 1'b1;
          end
          m_pos++;
        end
      end

      // Compare every cycle once reset has been seen; also mirror DUT RAM writes.
      forever begin
        bit exp_ready;
        bit exp_hold;
        @(negedge clk);
        if (armed) begin
          exp_ready = m_active && !m_wr;
          exp_hold  = m_active || m_err;
          total++;
          if (bus.rx_ready !== exp_ready || bus.ram_we !== m_wr || bus.ram_addr !== m_addr ||
              bus.ram_data !== m_data || cpu_hold !== exp_hold || done !== m_done ||
              err !== m_err || word_cnt !== CNT_W'(m_cnt)) begin
            bad++;
            $display("FAIL cycle_check t=%0t: got rdy=%b we=%b addr=%0h data=%0h hold=%b done=%b err=%b cnt=%0d want rdy=%b we=%b addr=%0h data=%0h hold=%b done=%b err=%b cnt=%0d",
                     $time, bus.rx_ready, bus.ram_we, bus.ram_addr, bus.ram_data, cpu_hold, done, err, word_cnt,
                     exp_ready, m_wr, m_addr, m_data, exp_hold, m_done, m_err, m_cnt);
          end
          if (bus.ram_we === 1'b1) begin
            dut_ram[bus.ram_addr] = bus.ram_data;
            we_count++;
          end
        end
      end

      begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1, "watchdog");
      end
    join_none

    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_rdy", 32'(bus.rx_ready), 32'd0);
    check("reset_we", 32'(bus.ram_we), 32'd0);
    check("reset_addr", 32'(bus.ram_addr), 32'(BASE_ADDR));
    check("reset_data", 32'(bus.ram_data), 32'd0);
    check("reset_hold", 32'(cpu_hold), 32'd0);
    check("reset_flags", 32'({done, err}), 32'd0);
    check("reset_cnt", 32'(word_cnt), 32'd0);

    // Normal load.
    pulse_start();
    check("start_hold", 32'(cpu_hold), 32'd1);
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    w0 = we_count;
    send_frame(0, 0);
    tick();
    check("normal_ram0", 32'(dut_ram[0]), 32'h1234);
    check("normal_ram1", 32'(dut_ram[1]), 32'hABCD);
    check("normal_we", 32'(we_count - w0), 32'd2);
    check("normal_flags", 32'({done, err, cpu_hold}), 32'b100);
    check("normal_cnt", 32'(word_cnt), 32'd2);

    // Bad checksum.
    dut_ram[0] = 16'h0; dut_ram[1] = 16'h0;
    pulse_start();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    w0 = we_count;
    send_frame(0, 0);
    tick();
    check("badck_flags", 32'({done, err, cpu_hold}), 32'b011);
    check("badck_we", 32'(we_count - w0), 32'd2);
    check("badck_ram", 32'({dut_ram[0], dut_ram[1]}), 32'h1234ABCD);

    // Length overflow.
    pulse_start();
    frame = '{8'h04, 8'h01};
    w0 = we_count;
    send_frame(0, 0);
    tick();
    check("ovf_err", 32'({done, err}), 32'b01);
    check("ovf_we", 32'(we_count - w0), 32'd0);
    check("ovf_rdy", 32'(bus.rx_ready), 32'd0);

    // Zero length with 5-cycle stalls.
    pulse_start();
    frame = '{8'h00, 8'h00, 8'h00};
    w0 = we_count;
    send_frame(5, 5);
    tick();
    check("zero_flags", 32'({done, err}), 32'b10);
    check("zero_cnt", 32'(word_cnt), 32'd0);
    check("zero_we", 32'(we_count - w0), 32'd0);

    // Reset mid-load, then a full reload.
    pulse_start();
    frame = '{8'h00, 8'h02, 8'h12};
    w0 = we_count;
    send_frame(0, 0);
    rst = 1'b1;
    tick();
    check("midrst_outs", 32'({bus.rx_ready, bus.ram_we, cpu_hold, done, err}), 32'd0);
    check("midrst_cnt", 32'(word_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check("midrst_we", 32'(we_count - w0), 32'd0);
    pulse_start();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    send_frame(0, 0);
    tick();
    check("reload_done", 32'({done, err}), 32'b10);
    check("reload_ram", 32'({dut_ram[0], dut_ram[1]}), 32'h1234ABCD);

    // Start during DATA_HI is ignored; Start after DONE begins a new load.
    pulse_start();
    frame = '{8'h00, 8'h02, 8'h11, 8'h22};
    send_frame(0, 0);
    pulse_start();
    frame = '{8'h33, 8'h44, 8'h46};
    send_frame(0, 0);
    tick();
    check("ignstart_done", 32'({done, err}), 32'b10);
    check("ignstart_ram1", 32'(dut_ram[1]), 32'h3344);
    pulse_start();
    check("restart_clr", 32'({done, cpu_hold}), 32'b01);
    frame = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
    send_frame(0, 0);
    tick();
    check("restart_ram0", 32'(dut_ram[0]), 32'hBEEF);
    check("restart_done", 32'({done, word_cnt}), 32'({1'b1, 11'd1}));

    // Randomized frames: good, corrupt, overflow, truncated by reset, one full-depth.
    for (int k = 0; k < 24; k++) begin
      int  kind;
      int  n;
      int  mism;
      int  lim;
      bit  trunc;
      bit  corrupt;
      bit  ovf;
      kind = int'($urandom_range(0, 9));
      if (k == 5) kind = 9;
      ovf = (kind == 0);
      corrupt = (kind == 1);
      trunc = (kind == 2);
      n = (k == 5) ? int'(DEPTH) : int'($urandom_range(0, 8));
      if (ovf) n = int'(DEPTH) + 1 + int'($urandom_range(0, 3));
      build_frame(n, corrupt);
      if (ovf) begin
        frame = frame[0:1];
      end else if (trunc) begin
        lim = int'($urandom_range(1, frame.size() - 1));
        frame = frame[0:lim-1];
      end
      pulse_start();
      start_noise = 1'b1;
      send_frame(0, 3);
      start_noise = 1'b0;
      if (trunc) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
      check("rand_done", 32'(done), 32'(!trunc && !ovf && !corrupt));
      check("rand_err", 32'(err), 32'(!trunc && (ovf || corrupt)));
      mism = 0;
      lim = ovf ? 0 : n;
      for (int a = 0; a < lim; a++) begin
        if (dut_ram[int'(BASE_ADDR) + a] !== mram[int'(BASE_ADDR) + a]) mism++;
      end
      check("rand_ram", 32'(mism), 32'd0);
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
